// File: rtl/iob_gray_sync_decoder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | iob_gray_sync_decoder_pkg: shared gray-code helpers for counters/pointers  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package iob_gray_sync_decoder_pkg;

  localparam int DEFAULT_SYNC_STAGES = 2;
  // Helpers operate on a zero-extended word; callers truncate back to their width.
  localparam int GRAY_MAX_W = 64;

  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b = g;
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic gray_step_legal(input logic [GRAY_MAX_W-1:0] a,
                                           input logic [GRAY_MAX_W-1:0] b);
    int unsigned n;
    n = 0;
    for (int i = 0; i < GRAY_MAX_W; i++) begin
      if (a[i] != b[i]) n++;
    end
    return (n <= 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/iob_gray_sync_decoder_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | iob_sync: W-bit multi-flop synchronizer, async active-low reset to zero    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module iob_sync #(
  parameter int W      = 4,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] stage_q [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) stage_q[s] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int s = 1; s < STAGES; s++) stage_q[s] <= stage_q[s-1];
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/iob_gray_sync_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | iob_gray_sync_decoder: synchronize a remote gray count, decode to binary,  |
// | report advance per update and flag illegal multi-bit steps.                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module iob_gray_sync_decoder
  import iob_gray_sync_decoder_pkg::*;
#(
  parameter int W           = 4,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] gray_in,
  input  logic         err_clr,
  output logic [W-1:0] gray_sync_out,
  output logic [W-1:0] bin_out,
  output logic [W-1:0] delta,
  output logic         update,
  output logic         err
);

  logic [W-1:0]            gray_sync;
  logic [GRAY_MAX_W-1:0]   gray_ext;
  logic [GRAY_MAX_W-1:0]   prev_ext;
  logic [W-1:0]            bin_new;
  logic                    changed;
  logic                    legal;

  logic [W-1:0] gray_prev_q, gray_prev_d;
  logic [W-1:0] bin_q, bin_d;
  logic [W-1:0] delta_q, delta_d;
  logic         update_q, update_d;
  logic         err_q, err_d;

  iob_sync #(
    .W      (W),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (gray_in),
    .q_o   (gray_sync)
  );

  always_comb begin
    gray_ext          = '0;
    prev_ext          = '0;
    gray_ext[W-1:0]   = gray_sync;
    prev_ext[W-1:0]   = gray_prev_q;
  end

  assign bin_new = W'(gray2bin(gray_ext));
  assign changed = (gray_sync != gray_prev_q);
  assign legal   = gray_step_legal(gray_ext, prev_ext);

  always_comb begin
    gray_prev_d = gray_prev_q;
    bin_d       = bin_q;
    delta_d     = delta_q;
    update_d    = 1'b0;
    err_d       = err_q;
    if (changed) begin
      gray_prev_d = gray_sync;
      bin_d       = bin_new;
      delta_d     = bin_new - bin_q;
      update_d    = 1'b1;
    end
    // A fresh violation outranks a clear arriving on the same edge.
    if (err_clr) err_d = 1'b0;
    if (changed && !legal) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gray_prev_q <= '0;
      bin_q       <= '0;
      delta_q     <= '0;
      update_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      gray_prev_q <= gray_prev_d;
      bin_q       <= bin_d;
      delta_q     <= delta_d;
      update_q    <= update_d;
      err_q       <= err_d;
    end
  end

  assign gray_sync_out = gray_sync;
  assign bin_out       = bin_q;
  assign delta         = delta_q;
  assign update        = update_q;
  assign err           = err_q;

endmodule
`default_nettype wire

// File: tb/tb_iob_gray_sync_decoder.sv
`default_nettype none
// Directed bench for iob_gray_sync_decoder at W=4 and W=1 with a scoreboard queue.
module tb_iob_gray_sync_decoder;

  typedef struct {
    logic [3:0] bin;
    logic [3:0] delta;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] g4;
  logic       clr4;
  logic [0:0] g1;
  logic       clr1;

  logic [3:0] gs4, b4, d4;
  logic       up4, e4;
  logic [0:0] gs1, b1, d1;
  logic       up1, e1;

  int total = 0;
  int bad   = 0;

  exp_t       sb[$];
  logic [3:0] m_bin  [2];
  logic [3:0] m_prev [2];
  logic       m_err  [2];

  always #5 clk = ~clk;

  iob_gray_sync_decoder #(.W(4), .SYNC_STAGES(2)) u4 (
    .clk(clk), .rst_n(rst_n), .gray_in(g4), .err_clr(clr4),
    .gray_sync_out(gs4), .bin_out(b4), .delta(d4), .update(up4), .err(e4)
  );

  iob_gray_sync_decoder #(.W(1), .SYNC_STAGES(2)) u1 (
    .clk(clk), .rst_n(rst_n), .gray_in(g1), .err_clr(clr1),
    .gray_sync_out(gs1), .bin_out(b1), .delta(d1), .update(up1), .err(e1)
  );

  function automatic logic [3:0] tb_g2b(input logic [3:0] g);
    logic [3:0] b;
    b = g;
    for (int s = 1; s < 4; s++) b = b ^ (g >> s);
    return b;
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_bin[s]  = 4'h0;
      m_prev[s] = 4'h0;
      m_err[s]  = 1'b0;
    end
  endtask

  // Entered and left on a falling edge; asserts reset without any clock edge.
  task automatic do_reset();
    rst_n = 1'b0;
    g4    = 4'h0;
    g1    = 1'b0;
    #1;
    chk("rst_gray_sync", gs4, 4'h0);
    chk("rst_bin", b4, 4'h0);
    chk("rst_delta", d4, 4'h0);
    chk("rst_update", {3'b0, up4}, 4'h0);
    chk("rst_err", {3'b0, e4}, 4'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Drive a new gray value, push the expected update, then watch 4 edges.
  task automatic step(input bit s, input logic [3:0] g_in, input bit clr);
    exp_t       e;
    logic [3:0] mask, g, nb;
    logic [3:0] o_gs, o_b, o_d;
    logic       o_up, o_e;
    mask = s ? 4'h1 : 4'hF;
    g    = g_in & mask;
    if (s) g1 = g[0:0]; else g4 = g;
    nb      = tb_g2b(g);
    e.bin   = nb;
    e.delta = (nb - m_bin[s]) & mask;
    e.err   = (clr ? 1'b0 : m_err[s]) | ($countones(g ^ m_prev[s]) > 1);
    sb.push_back(e);
    m_bin[s]  = nb;
    m_prev[s] = g;
    m_err[s]  = e.err;
    for (int k = 1; k <= 4; k++) begin
      if (k == 3) clr4 = clr;
      @(posedge clk);
      #1;
      clr4 = 1'b0;
      if (s) begin
        o_gs = {3'b0, gs1}; o_b = {3'b0, b1}; o_d = {3'b0, d1}; o_up = up1; o_e = e1;
      end else begin
        o_gs = gs4; o_b = b4; o_d = d4; o_up = up4; o_e = e4;
      end
      if (k == 2) chk("gray_sync_out", o_gs, g);
      if (k == 3) begin
        chk("update_pulse", {3'b0, o_up}, 4'h1);
        if (sb.size() == 0) begin
          chk("scoreboard_empty", 4'h1, 4'h0);
        end else begin
          e = sb.pop_front();
          chk("bin_out", o_b, e.bin);
          chk("delta", o_d, e.delta);
          chk("err", {3'b0, o_e}, {3'b0, e.err});
        end
      end else begin
        chk("update_idle", {3'b0, o_up}, 4'h0);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_chk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      chk("idle_update", {3'b0, up4}, 4'h0);
      chk("sticky_err", {3'b0, e4}, {3'b0, m_err[0]});
    end
    @(negedge clk);
  endtask

  task automatic clr_pulse();
    clr4 = 1'b1;
    @(posedge clk);
    #1;
    clr4 = 1'b0;
    m_err[0] = 1'b0;
    chk("err_after_clr", {3'b0, e4}, 4'h0);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    g4    = 4'b0110;
    g1    = 1'b0;
    clr4  = 1'b0;
    clr1  = 1'b0;
    model_reset();
    #1;
    chk("por_gray_sync", gs4, 4'h0);
    chk("por_bin", b4, 4'h0);
    chk("por_delta", d4, 4'h0);
    chk("por_update", {3'b0, up4}, 4'h0);
    chk("por_err", {3'b0, e4}, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 4'b0110, 1'b0);

    do_reset();
    step(1'b0, 4'b0001, 1'b0);
    step(1'b0, 4'b0011, 1'b0);
    step(1'b0, 4'b0010, 1'b0);

    for (int v = 4; v < 16; v++) step(1'b0, 4'(v ^ (v >> 1)), 1'b0);
    step(1'b0, 4'b0000, 1'b0);

    step(1'b0, 4'b0011, 1'b0);
    idle_chk(3);
    clr_pulse();
    step(1'b0, 4'b0101, 1'b1);
    idle_chk(2);

    step(1'b0, 4'b0111, 1'b0);
    do_reset();
    step(1'b0, 4'b0001, 1'b0);

    step(1'b1, 4'b0001, 1'b0);
    step(1'b1, 4'b0000, 1'b0);
    step(1'b1, 4'b0001, 1'b0);

    chk("scoreboard_drained", 4'(sb.size()), 4'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
